// File: rtl/row_pe_pkg.sv
// Shared types for the row_pe arbiter: FSM state encoding and requester-id width helper.
package row_pe_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

  // Never narrower than one bit so two requesters still get a usable id.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/row_pe_arbiter_owner_fifo.sv
// In-order FIFO of row owners; head is the requester whose result row the PE emits next.
module owner_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_id,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_id;
  end

endmodule

// File: rtl/row_pe_arbiter.sv
// Row-granular round-robin arbiter sharing one row_pe between N_REQ streams.
// Optional per-requester row/frame counters with ROW_PE_ARB_STATS_EN.
module row_pe_arbiter
  import row_pe_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_REQ     = 3,
  parameter int OWN_DEPTH = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req_vld,
  input  logic [N_REQ-1:0]          i_req_eor,
  input  logic [N_REQ-1:0]          i_req_eof,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]          o_req_rdy,
  output logic                      o_pe_vld,
  output logic                      o_pe_eor,
  output logic                      o_pe_eof,
  output logic [DATA_W-1:0]         o_pe_data,
  input  logic                      i_pe_rdy,
  input  logic                      i_pe_vld,
  input  logic                      i_pe_eor,
  input  logic                      i_pe_eof,
  input  logic [DATA_W-1:0]         i_pe_data,
  output logic                      o_pe_rdy,
  output logic [N_REQ-1:0]          o_res_vld,
  output logic [N_REQ-1:0]          o_res_eor,
  output logic [N_REQ-1:0]          o_res_eof,
  output logic [DATA_W-1:0]         o_res_data,
  input  logic [N_REQ-1:0]          i_res_rdy,
  output logic                      o_err,
  output logic [N_REQ*STAT_W-1:0]   o_stat_rows,
  output logic [N_REQ*STAT_W-1:0]   o_stat_frames
);

  localparam int ID_W = id_w(N_REQ);

  arb_state_t      r_state, w_state_nxt;
  logic [ID_W-1:0] r_grant_id, w_grant_nxt;
  logic [ID_W-1:0] r_rr_ptr, w_rr_nxt;
  logic [ID_W-1:0] w_win_id;
  logic            w_win_vld;
  logic            w_eor_acc;
  logic            w_push, w_pop, w_full, w_empty;
  logic [ID_W-1:0] w_own_id;
  logic            r_err;

  owner_fifo #(.W(ID_W), .DEPTH(OWN_DEPTH)) u_owner_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (w_push),
    .i_push_id (r_grant_id),
    .i_pop     (w_pop),
    .o_head    (w_own_id),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // First valid requester at or after rr_ptr, searching cyclically.
  always_comb begin
    int idx;
    w_win_vld = 1'b0;
    w_win_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(r_rr_ptr) + i) % N_REQ;
      if (!w_win_vld && i_req_vld[idx]) begin
        w_win_vld = 1'b1;
        w_win_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    o_req_rdy = '0;
    o_pe_vld  = 1'b0;
    o_pe_eor  = 1'b0;
    o_pe_eof  = 1'b0;
    o_pe_data = i_req_data[int'(r_grant_id)*DATA_W +: DATA_W];
    if (r_state == ST_GRANT) begin
      o_pe_vld              = i_req_vld[r_grant_id];
      o_pe_eor              = i_req_eor[r_grant_id];
      o_pe_eof              = i_req_eof[r_grant_id];
      o_req_rdy[r_grant_id] = i_pe_rdy;
    end
  end

  assign w_eor_acc = (r_state == ST_GRANT) & o_pe_vld & i_pe_rdy & o_pe_eor;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_rr_nxt    = r_rr_ptr;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld && !w_full) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_win_id;
        end
      end
      ST_GRANT: begin
        if (w_eor_acc) begin
          w_state_nxt = ST_IDLE;
          w_push      = 1'b1;
          w_rr_nxt    = (r_grant_id == ID_W'(N_REQ-1)) ? '0 : r_grant_id + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_rr_ptr   <= w_rr_nxt;
    end
  end

  // With no owner recorded the PE output is drained and flagged as an error.
  always_comb begin
    o_res_vld  = '0;
    o_res_eor  = '0;
    o_res_eof  = '0;
    o_res_data = i_pe_data;
    o_pe_rdy   = 1'b1;
    w_pop      = 1'b0;
    if (!w_empty) begin
      o_res_vld[w_own_id] = i_pe_vld;
      o_res_eor[w_own_id] = i_pe_eor;
      o_res_eof[w_own_id] = i_pe_eof;
      o_pe_rdy            = i_res_rdy[w_own_id];
      w_pop               = i_pe_vld & i_res_rdy[w_own_id] & i_pe_eor;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                r_err <= 1'b0;
    else if (w_empty & i_pe_vld) r_err <= 1'b1;
  end

  assign o_err = r_err;

`ifdef ROW_PE_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_rows   [N_REQ];
  logic [STAT_W-1:0] r_stat_frames [N_REQ];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_REQ; k++) begin
        r_stat_rows[k]   <= '0;
        r_stat_frames[k] <= '0;
      end
    end else if (w_pop) begin
      r_stat_rows[w_own_id] <= r_stat_rows[w_own_id] + 1'b1;
      if (i_pe_eof) r_stat_frames[w_own_id] <= r_stat_frames[w_own_id] + 1'b1;
    end
  end

  always_comb begin
    o_stat_rows   = '0;
    o_stat_frames = '0;
    for (int k = 0; k < N_REQ; k++) begin
      o_stat_rows[k*STAT_W +: STAT_W]   = r_stat_rows[k];
      o_stat_frames[k*STAT_W +: STAT_W] = r_stat_frames[k];
    end
  end
`else
  assign o_stat_rows   = '0;
  assign o_stat_frames = '0;
`endif

endmodule

// File: tb/tb_row_pe_arbiter.sv
// Directed bench for row_pe_arbiter; the bench plays both the requesters and the row_pe.
module tb_row_pe_arbiter;

  localparam int DW = 8;
  localparam int NR = 3;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_vld, req_eor, req_eof, req_rdy;
  logic [NR*DW-1:0] req_data;
  logic            pe_in_vld, pe_in_eor, pe_in_eof, pe_in_rdy;
  logic [DW-1:0]   pe_in_data;
  logic            pe_out_vld, pe_out_eor, pe_out_eof, pe_out_rdy;
  logic [DW-1:0]   pe_out_data;
  logic [NR-1:0]   res_vld, res_eor, res_eof, res_rdy;
  logic [DW-1:0]   res_data;
  logic            err;
  logic [NR*16-1:0] stat_rows, stat_frames;

  row_pe_arbiter #(.DATA_W(DW), .N_REQ(NR), .OWN_DEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_vld(req_vld), .i_req_eor(req_eor), .i_req_eof(req_eof), .i_req_data(req_data),
    .o_req_rdy(req_rdy),
    .o_pe_vld(pe_in_vld), .o_pe_eor(pe_in_eor), .o_pe_eof(pe_in_eof), .o_pe_data(pe_in_data),
    .i_pe_rdy(pe_in_rdy),
    .i_pe_vld(pe_out_vld), .i_pe_eor(pe_out_eor), .i_pe_eof(pe_out_eof), .i_pe_data(pe_out_data),
    .o_pe_rdy(pe_out_rdy),
    .o_res_vld(res_vld), .o_res_eor(res_eor), .o_res_eof(res_eof), .o_res_data(res_data),
    .i_res_rdy(res_rdy),
    .o_err(err),
    .o_stat_rows(stat_rows), .o_stat_frames(stat_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester sources: pixel = k*64 + row*8 + pix.
  int src_rows[NR], src_len[NR], src_pix[NR], src_row[NR];
  bit src_eof[NR];
  bit auto_ret;
  bit ret_q[$];
  int res_cnt;
  int cyc;
  logic [NR-1:0] fire;
  logic [7:0] pe_data_q[$];
  bit pe_eor_q[$];
  int pe_cyc_q[$];
  int eor_own_q[$];
  int res_own_q[$];

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_vld[k] = (src_rows[k] > 0);
      req_data[k*DW +: DW] = 8'(k*64 + src_row[k]*8 + src_pix[k]);
      req_eor[k] = (src_pix[k] == src_len[k]-1);
      req_eof[k] = src_eof[k] && (src_rows[k] == 1) && (src_pix[k] == src_len[k]-1);
    end
    if (auto_ret) begin
      pe_out_vld  = (ret_q.size() > 0);
      pe_out_eor  = 1'b1;
      pe_out_eof  = (ret_q.size() > 0) ? ret_q[0] : 1'b0;
      pe_out_data = 8'(8'hC0 + res_cnt);
    end
  endtask

  task automatic sample();
    int own;
    cyc++;
    fire = req_rdy & req_vld;
    if (auto_ret && pe_out_vld && pe_out_rdy) begin
      own = -1;
      for (int k = 0; k < NR; k++) if (res_vld[k]) own = k;
      res_own_q.push_back(own);
      res_cnt++;
      void'(ret_q.pop_front());
    end
    if (pe_in_vld && pe_in_rdy) begin
      pe_data_q.push_back(pe_in_data);
      pe_eor_q.push_back(pe_in_eor);
      pe_cyc_q.push_back(cyc);
      if (pe_in_eor) begin
        eor_own_q.push_back(int'(pe_in_data) / 64);
        if (auto_ret) ret_q.push_back(pe_in_eof);
      end
    end
  endtask

  task automatic advance();
    for (int k = 0; k < NR; k++) begin
      if (fire[k]) begin
        if (src_pix[k] == src_len[k]-1) begin
          src_pix[k] = 0;
          src_rows[k]--;
          src_row[k]++;
        end else begin
          src_pix[k]++;
        end
      end
    end
    drive();
  endtask

  // Entered and left at a negedge with inputs settled.
  task automatic tick();
    #1;
    sample();
    @(posedge clk);
    #1;
    advance();
    @(negedge clk);
  endtask

  task automatic start_src(input int k, input int rows, input int len, input bit eof);
    src_rows[k] = rows;
    src_len[k]  = len;
    src_pix[k]  = 0;
    src_row[k]  = 0;
    src_eof[k]  = eof;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NR; k++) begin
      src_rows[k] = 0; src_len[k] = 1; src_pix[k] = 0; src_row[k] = 0; src_eof[k] = 0;
    end
    auto_ret = 0;
    ret_q.delete();
    res_cnt = 0;
    pe_in_rdy = 1'b1;
    pe_out_vld = 1'b0; pe_out_eor = 1'b0; pe_out_eof = 1'b0; pe_out_data = '0;
    res_rdy = '1;
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    pe_data_q.delete(); pe_eor_q.delete(); pe_cyc_q.delete();
    eor_own_q.delete(); res_own_q.delete();
    #1;
  endtask

  initial begin
    int exp_own[4];
    int exp_row[4];
    rst_n = 1'b0;
    req_vld = '0; req_eor = '0; req_eof = '0; req_data = '0;
    cyc = 0;
    @(negedge clk);
    do_reset();

    chk("rst_req_rdy", 32'(req_rdy), 0);
    chk("rst_pe_vld",  32'(pe_in_vld), 0);
    chk("rst_res_vld", 32'(res_vld), 0);
    chk("rst_pe_rdy",  32'(pe_out_rdy), 1);
    chk("rst_err",     32'(err), 0);
`ifndef ROW_PE_ARB_STATS_EN
    chk("nostat_rows",   32'(stat_rows != '0), 0);
    chk("nostat_frames", 32'(stat_frames != '0), 0);
`endif

    // Single requester 1, one 5-pixel row, then its result row.
    start_src(1, 1, 5, 0);
    for (int c = 0; c < 20 && pe_data_q.size() < 5; c++) tick();
    chk("t1_beats", pe_data_q.size(), 5);
    for (int i = 0; i < 5 && i < pe_data_q.size(); i++) begin
      chk("t1_data", 32'(pe_data_q[i]), 32'(64 + i));
      chk("t1_eor",  32'(pe_eor_q[i]), 32'(i == 4));
    end
    for (int i = 0; i < 5; i++) begin
      pe_out_vld = 1'b1; pe_out_data = 8'(8'hA0 + i); pe_out_eor = (i == 4); pe_out_eof = 1'b0;
      #1;
      chk("t1_res_vld",  32'(res_vld), 32'b010);
      chk("t1_res_data", 32'(res_data), 32'(8'hA0 + i));
      chk("t1_res_eor",  32'(res_eor), (i == 4) ? 32'b010 : 32'b000);
      chk("t1_pe_rdy",   32'(pe_out_rdy), 1);
      tick();
    end
    pe_out_vld = 1'b0; pe_out_eor = 1'b0;
    tick();
    chk("t1_err", 32'(err), 0);

    // All three requesters valid, 4-pixel rows: grant order 0,1,2,0 with one-cycle bubbles.
    do_reset();
    auto_ret = 1;
    start_src(0, 2, 4, 0);
    start_src(1, 1, 4, 0);
    start_src(2, 1, 4, 0);
    for (int c = 0; c < 60 && res_own_q.size() < 4; c++) tick();
    exp_own = '{0, 1, 2, 0};
    exp_row = '{0, 0, 0, 1};
    chk("t2_rows", eor_own_q.size(), 4);
    chk("t2_beats", pe_data_q.size(), 16);
    chk("t2_res_rows", res_own_q.size(), 4);
    for (int r = 0; r < 4 && r < eor_own_q.size() && r < res_own_q.size(); r++) begin
      chk("t2_order", eor_own_q[r], exp_own[r]);
      chk("t2_res_owner", res_own_q[r], exp_own[r]);
    end
    for (int b = 0; b < 16 && b < pe_data_q.size(); b++)
      chk("t2_data", 32'(pe_data_q[b]), 32'(exp_own[b/4]*64 + exp_row[b/4]*8 + b%4));
    for (int r = 0; r < 3 && 4*r+4 < pe_cyc_q.size(); r++)
      chk("t2_bubble", pe_cyc_q[4*r+4] - pe_cyc_q[4*r+3], 2);

    // PE input stalls for 3 cycles mid-row.
    do_reset();
    auto_ret = 1;
    start_src(0, 1, 6, 0);
    for (int c = 0; c < 20 && pe_data_q.size() < 2; c++) tick();
    pe_in_rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t3_hold_vld",  32'(pe_in_vld), 1);
      chk("t3_hold_data", 32'(pe_in_data), 2);
      chk("t3_hold_rdy",  32'(req_rdy), 0);
      tick();
    end
    pe_in_rdy = 1'b1;
    for (int c = 0; c < 20 && res_own_q.size() < 1; c++) tick();
    chk("t3_beats", pe_data_q.size(), 6);
    for (int i = 0; i < 6 && i < pe_data_q.size(); i++)
      chk("t3_data", 32'(pe_data_q[i]), 32'(i));

    // Owner FIFO fills while requester 0's result is back-pressured.
    do_reset();
    auto_ret = 1;
    res_rdy = 3'b110;
    start_src(0, 1, 2, 0);
    start_src(1, 1, 2, 0);
    start_src(2, 1, 2, 0);
    for (int c = 0; c < 15; c++) tick();
    chk("t4_pushed", eor_own_q.size(), 2);
    chk("t4_idle_vld", 32'(pe_in_vld), 0);
    chk("t4_idle_rdy", 32'(req_rdy), 0);
    chk("t4_res_vld",  32'(res_vld), 32'b001);
    chk("t4_pe_rdy",   32'(pe_out_rdy), 0);
    res_rdy = 3'b111;
    for (int c = 0; c < 30 && res_own_q.size() < 3; c++) tick();
    chk("t4_rows", eor_own_q.size(), 3);
    if (eor_own_q.size() == 3) chk("t4_third_grant", eor_own_q[2], 2);
    chk("t4_res_rows", res_own_q.size(), 3);
    for (int r = 0; r < 3 && r < res_own_q.size(); r++)
      chk("t4_res_owner", res_own_q[r], r);

    // Result beat with an empty owner FIFO.
    do_reset();
    pe_out_vld = 1'b1; pe_out_eor = 1'b0;
    #1;
    chk("t5_drain_rdy", 32'(pe_out_rdy), 1);
    chk("t5_res_vld",   32'(res_vld), 0);
    chk("t5_err_pre",   32'(err), 0);
    tick();
    chk("t5_err_set", 32'(err), 1);
    pe_out_vld = 1'b0;
    for (int j = 0; j < 3; j++) tick();
    chk("t5_err_sticky", 32'(err), 1);
    rst_n = 1'b0;
    tick();
    chk("t5_err_clr", 32'(err), 0);
    rst_n = 1'b1;

`ifdef ROW_PE_ARB_STATS_EN
    // Requester 2: three rows, last with eof.
    do_reset();
    auto_ret = 1;
    start_src(2, 3, 2, 1);
    for (int c = 0; c < 40 && res_own_q.size() < 3; c++) tick();
    tick();
    chk("t6_rows2",   32'(stat_rows[2*16 +: 16]), 3);
    chk("t6_frames2", 32'(stat_frames[2*16 +: 16]), 1);
    chk("t6_rows0",   32'(stat_rows[0 +: 16]), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/row_pe_arbiter.md
# row_pe_arbiter

Round-robin arbiter that time-shares one `row_pe` between `N_REQ` independent pixel-row streams (e.g. colour planes or tiles) at row granularity. It grants the PE input to one requester for a whole row, terminated by `eor`. It records the row owner in an in-order owner FIFO and steers each PE result row back to the requester that issued it. It sits between the requester-side stream sources and the `row_pe` instance, using the same vld/rdy/eor/eof stream protocol on every side.

## Interface
Parameters:
- `DATA_W`, 8, pixel width
- `N_REQ`, 3, number of requesters (2..8)
- `OWN_DEPTH`, 2, owner FIFO depth (power of two, ≥2); bounds rows in flight inside the PE

Ports (clock and reset first; one clock; reset is synchronous and active-low):
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  synchronous active-low reset
- `i_req_vld`  in  N_REQ  per-requester pixel valid
- `i_req_eor` / `i_req_eof`  in  N_REQ  per-requester end-of-row / end-of-file
- `i_req_data`  in  N_REQ*DATA_W  packed pixels, requester k at `[k*DATA_W +: DATA_W]`
- `o_req_rdy`  out  N_REQ  per-requester ready
- `o_pe_vld`, `o_pe_eor`, `o_pe_eof`  out  1  stream into `row_pe`
- `o_pe_data`  out  DATA_W  pixel into `row_pe`
- `i_pe_rdy`  in  1  `row_pe` input ready
- `i_pe_vld`, `i_pe_eor`, `i_pe_eof`  in  1  result stream from `row_pe`
- `i_pe_data`  in  DATA_W  result pixel
- `o_pe_rdy`  out  1  ready toward `row_pe` output
- `o_res_vld`, `o_res_eor`, `o_res_eof`  out  N_REQ  per-requester result stream
- `o_res_data`  out  DATA_W  shared result pixel, qualified by `o_res_vld[k]`
- `i_res_rdy`  in  N_REQ  per-requester result ready
- `o_err`  out  1  sticky: PE result beat arrived with owner FIFO empty

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: `grant_id` owns the PE input.
- IDLE → GRANT:
  - Condition: any `i_req_vld` high and owner FIFO not full.
  - Winner: first requester at or after `rr_ptr` (cyclic) with `vld` high. Latch it into `grant_id`.
- In GRANT, combinational mux:
  - `o_pe_{vld,eor,eof,data}` = requester `grant_id`.
  - `o_req_rdy[grant_id]` = `i_pe_rdy`; all other `o_req_rdy` = 0.
- GRANT → IDLE on the accepted `eor` beat (`o_pe_vld & i_pe_rdy & o_pe_eor`):
  - Push `grant_id` into the owner FIFO.
  - Set `rr_ptr` = `grant_id+1` (wrap to 0 at `N_REQ`).
- `eof` without `eor` is forwarded unchanged and does not end the grant.
- In IDLE, all `o_req_rdy` = 0 and `o_pe_vld` = 0.
- Return path (FIFO head `own_id`):
  - `o_res_{vld,eor,eof}[own_id]` = `i_pe_{vld,eor,eof}`; other bits 0.
  - `o_res_data` = `i_pe_data`.
  - `o_pe_rdy` = `i_res_rdy[own_id]`.
  - Pop on the accepted result `eor` beat.
- FIFO empty:
  - `o_pe_rdy` = 1 (drain) and all `o_res_vld` = 0.
  - Any `i_pe_vld` in this condition sets `o_err`; only reset clears it.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.

## Timing
- Reset (`i_rst_n`=0 at a clock edge): FSM IDLE, `rr_ptr`=0, FIFO empty, `o_err`=0. All `o_req_rdy`, `o_pe_vld`, `o_res_vld` = 0; `o_pe_rdy` = 1.
- Reset mid-row discards the grant and owner FIFO. The `row_pe` must be reset together with the arbiter.
- Arbitration bubble: exactly one cycle in IDLE between rows. The first beat of a granted row can be accepted in the cycle after the grant decision.
- Forward and return paths have zero added latency (pure muxes); the `row_pe` skid buffer breaks the rdy path.
- AXI-style rule: `o_pe_*` are held stable while `o_pe_vld & !i_pe_rdy`, because the grant cannot change before the `eor` is accepted.
- Owner FIFO full: stay in IDLE until a pop. A pop and a grant decision in the same cycle are allowed; the decision uses pre-pop fullness.

## Configuration
- `ROW_PE_ARB_STATS_EN` defined:
  - Per-requester 16-bit wrapping counters of completed result rows (popped `eor`) and frames (`eor&eof`).
  - Exposed on `o_stat_rows` / `o_stat_frames` (N_REQ*16 each); reset to 0.
- Not defined: counters are absent and both ports are driven to 0.

## Structure
- Shared package `row_pe_pkg`: FSM state typedef (IDLE/GRANT) and `ID_W = $clog2(N_REQ)` helper.
- One sub-module: `owner_fifo` (synchronous, width `ID_W`, depth `OWN_DEPTH`, full/empty flags, simultaneous push/pop).

## Test plan
- Only requester 1 sends a 5-pixel row (eor on pixel 5) → all 5 beats reach the PE, then `o_res_*[1]` gets the result row and `o_res_vld[0]`, `o_res_vld[2]` stay 0.
- All 3 requesters hold valid continuously, 4-pixel rows → grant order 0,1,2,0; exactly one idle cycle between rows.
- `i_pe_rdy` low for 3 cycles mid-row → `o_pe_data` stable and `o_req_rdy[grant_id]`=0 throughout; no beat is lost or duplicated.
- `i_res_rdy[0]`=0 while requesters 1 and 2 queue rows → after 2 owners are pushed the arbiter stays IDLE; releasing `i_res_rdy[0]` pops one owner and grants requester 2.
- Inject `i_pe_vld`=1 with the FIFO empty → `o_err`=1 next cycle, held until `i_rst_n`=0.
- With `ROW_PE_ARB_STATS_EN`, requester 2 sends 3 rows, the last with eof → `o_stat_rows[2]`=3, `o_stat_frames[2]`=1.
